// File: rtl/mul_div_unit_if.sv
// Operand/result bundle between the E-stage datapath and the mul/div unit.
interface mul_div_unit_if;
  logic        start;
  logic [2:0]  mdop;
  logic [31:0] A;
  logic [31:0] B;
  logic        M_in_D;
  logic        busy;
  logic        stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, mdop, A, B, M_in_D,
    input  busy, stall, HI, LO
  );

  modport slave (
    input  start, mdop, A, B, M_in_D,
    output busy, stall, HI, LO
  );
endinterface

// File: rtl/mul_div_unit.sv
// E-stage multiply/divide unit owning HI/LO; results commit after a
// fixed busy window and D-stage mul/div users are stalled meanwhile.
module mul_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic           clk,
  input  logic           reset_n,
  mul_div_unit_if.slave  md
);

  typedef enum logic {S_IDLE, S_BUSY} state_e;

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [31:0]   sh_hi_q, sh_hi_d;
  logic [31:0]   sh_lo_q, sh_lo_d;
  logic          sh_en_q, sh_en_d;

  logic op_mult, op_multu, op_div, op_divu;
  logic op_mthi, op_mtlo;
  logic is_mul, is_div, is_md;

  always_comb begin
    op_mult  = 1'b0;
    op_multu = 1'b0;
    op_div   = 1'b0;
    op_divu  = 1'b0;
    op_mthi  = 1'b0;
    op_mtlo  = 1'b0;
    unique case (1'b1)
      md.mdop == 3'd1: op_mult  = 1'b1;
      md.mdop == 3'd2: op_multu = 1'b1;
      md.mdop == 3'd3: op_div   = 1'b1;
      md.mdop == 3'd4: op_divu  = 1'b1;
      md.mdop == 3'd5: op_mthi  = 1'b1;
      md.mdop == 3'd6: op_mtlo  = 1'b1;
      default: ;
    endcase
  end

  assign is_mul = op_mult | op_multu;
  assign is_div = op_div | op_divu;
  assign is_md  = is_mul | is_div;

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               b_zero;
  logic [31:0]        den_u, qu, ru;
  logic [31:0]        mag_a, mag_b, den_s;
  logic [31:0]        qs_m, rs_m, qs, rs;
  logic [63:0]        res;

  // Signed divide works on magnitudes so MIN/-1 needs no special case.
  always_comb begin
    prod_s = $signed({{32{md.A[31]}}, md.A})
           * $signed({{32{md.B[31]}}, md.B});
    prod_u = {32'd0, md.A} * {32'd0, md.B};
    b_zero = (md.B == 32'd0);
    den_u  = b_zero ? 32'd1 : md.B;
    qu     = md.A / den_u;
    ru     = md.A % den_u;
    mag_a  = md.A[31] ? (32'd0 - md.A) : md.A;
    mag_b  = md.B[31] ? (32'd0 - md.B) : md.B;
    den_s  = b_zero ? 32'd1 : mag_b;
    qs_m   = mag_a / den_s;
    rs_m   = mag_a % den_s;
    qs     = (md.A[31] ^ md.B[31]) ? (32'd0 - qs_m) : qs_m;
    rs     = md.A[31] ? (32'd0 - rs_m) : rs_m;
    res    = 64'd0;
    unique case (1'b1)
      op_mult:  res = prod_s;
      op_multu: res = prod_u;
      op_div:   res = {rs, qs};
      op_divu:  res = {ru, qu};
      default:  res = 64'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_en_d = sh_en_q;
    unique case (state_q)
      S_IDLE: begin
        if (md.start && is_md) begin
          sh_hi_d = res[63:32];
          sh_lo_d = res[31:0];
          sh_en_d = !(is_div && b_zero);
          cnt_d   = is_mul ? MULT_N : DIV_N;
          busy_d  = 1'b1;
          state_d = S_BUSY;
        end else if (md.start && op_mthi) begin
          hi_d = md.A;
        end else if (md.start && op_mtlo) begin
          lo_d = md.A;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
          if (sh_en_q) begin
            hi_d = sh_hi_q;
            lo_d = sh_lo_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      sh_hi_q <= 32'd0;
      sh_lo_q <= 32'd0;
      sh_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_en_q <= sh_en_d;
    end
  end

  assign md.busy  = busy_q;
  assign md.stall = md.M_in_D & (busy_q | (md.start & is_md));
  assign md.HI    = hi_q;
  assign md.LO    = lo_q;

endmodule
